mul_share_arbiter: RTL and testbench

MUL_SHARE_ARBITER -- requirements
Module: mul_share_arbiter

---
 rtl/mul_share_arbiter_if.sv | 34 +++
 rtl/mul_share_arbiter.sv | 130 +++++++++++++
 tb/tb_mul_share_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_share_arbiter_if.sv
// Request/response bundle between two requesters and the shared multiplier arbiter.
// The slave modport is the arbiter side; the master modport is the requester side.
interface mul_share_arbiter_if;
    logic               req0_valid;
    logic               req1_valid;
    logic               req0_ready;
    logic               req1_ready;
    logic signed [15:0] req0_a;
    logic signed [15:0] req0_b;
    logic signed [15:0] req1_a;
    logic signed [15:0] req1_b;
    logic               rsp0_valid;
    logic               rsp1_valid;
    logic               rsp0_ready;
    logic               rsp1_ready;
    logic signed [31:0] rsp0_pro;
    logic signed [31:0] rsp1_pro;
    logic               busy;
    logic               grant;

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        output rsp0_pro, rsp1_pro, busy, grant
    );

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        input  rsp0_pro, rsp1_pro, busy, grant
    );
endinterface

// File: rtl/mul_share_arbiter.sv
// Two-requester arbiter sharing one 16x16 signed combinational multiplier.
// Each transaction walks IDLE -> CALC -> RESP; operands are latched at accept.

module mul16s (
    input  logic signed [15:0] a,
    input  logic signed [15:0] b,
    output logic signed [31:0] pro
);
    assign pro = a * b;
endmodule

module mul_share_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    mul_share_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    logic signed [15:0] r_a;
    logic signed [15:0] r_b;
    logic signed [31:0] r_product;
    logic               r_grant;
    logic               r_last_grant;
    logic               r_busy;
    logic               r_rsp0_valid;
    logic               r_rsp1_valid;

    logic               w_sel;
    logic               w_idle;
    logic               w_ready0;
    logic               w_ready1;
    logic               w_rsp_ready;
    logic signed [31:0] w_pro;

    mul16s u_mul (
        .a   (r_a),
        .b   (r_b),
        .pro (w_pro)
    );

    // Winner selection: fixed priority favours port 0, round-robin flips on ties.
    always_comb begin
        w_sel = 1'b0;
        if (FIXED_PRIO == 1'b1) begin
            w_sel = !bus.req0_valid;
        end else if (bus.req0_valid && bus.req1_valid) begin
            w_sel = !r_last_grant;
        end else begin
            w_sel = bus.req1_valid;
        end
    end

    // Ready is only offered in IDLE and never while reset is asserted.
    always_comb begin
        w_idle      = (r_state == S_IDLE) && !rst;
        w_ready0    = w_idle && !w_sel && bus.req0_valid;
        w_ready1    = w_idle &&  w_sel && bus.req1_valid;
        w_rsp_ready = r_grant ? bus.rsp1_ready : bus.rsp0_ready;
    end

    // Transaction FSM with registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_a          <= 16'sd0;
            r_b          <= 16'sd0;
            r_product    <= 32'sd0;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_busy       <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_ready0 || w_ready1) begin
                        r_a          <= w_ready1 ? bus.req1_a : bus.req0_a;
                        r_b          <= w_ready1 ? bus.req1_b : bus.req0_b;
                        r_grant      <= w_ready1;
                        r_last_grant <= w_ready1;
                        r_busy       <= 1'b1;
                        r_state      <= S_CALC;
                    end else begin
                        r_state      <= S_IDLE;
                    end
                end
                S_CALC: begin
                    r_product    <= w_pro;
                    r_rsp0_valid <= !r_grant;
                    r_rsp1_valid <= r_grant;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (w_rsp_ready) begin
                        r_rsp0_valid <= 1'b0;
                        r_rsp1_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_state      <= S_RESP;
                    end
                end
                default: begin
                    r_rsp0_valid <= 1'b0;
                    r_rsp1_valid <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    // Product is forced to zero on the port that holds no valid response.
    assign bus.rsp0_pro   = r_rsp0_valid ? r_product : 32'sd0;
    assign bus.rsp1_pro   = r_rsp1_valid ? r_product : 32'sd0;
    assign bus.rsp0_valid = r_rsp0_valid;
    assign bus.rsp1_valid = r_rsp1_valid;
    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
    assign bus.busy       = r_busy;
    assign bus.grant      = r_grant;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: a round-robin and a fixed-priority instance run
// side by side against a transaction-level reference model.
module tb_mul_share_arbiter;
    logic clk;
    logic [1:0] t_rst;
    logic [1:0] t_v0, t_v1, t_rr0, t_rr1;
    logic signed [15:0] t_a0 [2];
    logic signed [15:0] t_b0 [2];
    logic signed [15:0] t_a1 [2];
    logic signed [15:0] t_b1 [2];

    logic [1:0]  o_ready0, o_ready1, o_rv0, o_rv1, o_busy, o_grant;
    logic [31:0] o_pro0 [2];
    logic [31:0] o_pro1 [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one in-flight transaction per instance.
    bit m_inflight [2];
    int m_age      [2];
    bit m_port     [2];
    bit m_grant    [2];
    bit m_last     [2];
    int m_exp      [2];
    int m_acc      [2];

    int hs_dut[$];
    int hs_port[$];
    int hs_pro[$];

    mul_share_arbiter_if if_rr ();
    mul_share_arbiter_if if_fp ();

    mul_share_arbiter #(.FIXED_PRIO(1'b0)) u_rr (.clk(clk), .rst(t_rst[0]), .bus(if_rr));
    mul_share_arbiter #(.FIXED_PRIO(1'b1)) u_fp (.clk(clk), .rst(t_rst[1]), .bus(if_fp));

    assign if_rr.req0_valid = t_v0[0];
    assign if_rr.req1_valid = t_v1[0];
    assign if_rr.req0_a     = t_a0[0];
    assign if_rr.req0_b     = t_b0[0];
    assign if_rr.req1_a     = t_a1[0];
    assign if_rr.req1_b     = t_b1[0];
    assign if_rr.rsp0_ready = t_rr0[0];
    assign if_rr.rsp1_ready = t_rr1[0];
    assign if_fp.req0_valid = t_v0[1];
    assign if_fp.req1_valid = t_v1[1];
    assign if_fp.req0_a     = t_a0[1];
    assign if_fp.req0_b     = t_b0[1];
    assign if_fp.req1_a     = t_a1[1];
    assign if_fp.req1_b     = t_b1[1];
    assign if_fp.rsp0_ready = t_rr0[1];
    assign if_fp.rsp1_ready = t_rr1[1];

    assign o_ready0 = {if_fp.req0_ready, if_rr.req0_ready};
    assign o_ready1 = {if_fp.req1_ready, if_rr.req1_ready};
    assign o_rv0    = {if_fp.rsp0_valid, if_rr.rsp0_valid};
    assign o_rv1    = {if_fp.rsp1_valid, if_rr.rsp1_valid};
    assign o_busy   = {if_fp.busy, if_rr.busy};
    assign o_grant  = {if_fp.grant, if_rr.grant};
    assign o_pro0[0] = if_rr.rsp0_pro;
    assign o_pro0[1] = if_fp.rsp0_pro;
    assign o_pro1[0] = if_rr.rsp1_pro;
    assign o_pro1[1] = if_fp.rsp1_pro;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Port that wins arbitration in instance d given the current request lines.
    function automatic bit winner(input int d);
        if (d == 1) return !t_v0[d];
        if (t_v0[d] && t_v1[d]) return !m_last[d];
        return t_v1[d];
    endfunction

    function automatic void model_reset(input int d);
        m_inflight[d] = 1'b0;
        m_age[d]      = 0;
        m_port[d]     = 1'b0;
        m_grant[d]    = 1'b0;
        m_last[d]     = 1'b1;
        m_exp[d]      = 0;
    endfunction

    // One clock: compare all outputs with the model, advance the model, step the clock.
    task automatic tick();
        bit w, e_r0, e_r1, e_v0, e_v1;
        int pa, pb;
        string id;
        #1;
        for (int d = 0; d < 2; d++) begin
            id   = (d == 0) ? "rr" : "fp";
            w    = winner(d);
            e_r0 = !t_rst[d] && !m_inflight[d] && t_v0[d] && !w;
            e_r1 = !t_rst[d] && !m_inflight[d] && t_v1[d] && w;
            e_v0 = m_inflight[d] && (m_age[d] >= 1) && !m_port[d];
            e_v1 = m_inflight[d] && (m_age[d] >= 1) && m_port[d];
            check_value({id, " req0_ready"}, {31'd0, o_ready0[d]}, {31'd0, e_r0});
            check_value({id, " req1_ready"}, {31'd0, o_ready1[d]}, {31'd0, e_r1});
            check_value({id, " rsp0_valid"}, {31'd0, o_rv0[d]}, {31'd0, e_v0});
            check_value({id, " rsp1_valid"}, {31'd0, o_rv1[d]}, {31'd0, e_v1});
            check_value({id, " rsp0_pro"}, o_pro0[d], e_v0 ? m_exp[d] : 32'd0);
            check_value({id, " rsp1_pro"}, o_pro1[d], e_v1 ? m_exp[d] : 32'd0);
            check_value({id, " busy"}, {31'd0, o_busy[d]}, {31'd0, m_inflight[d]});
            check_value({id, " grant"}, {31'd0, o_grant[d]}, {31'd0, m_grant[d]});
            if (o_rv0[d] && t_rr0[d] && !t_rst[d]) begin
                hs_dut.push_back(d); hs_port.push_back(0); hs_pro.push_back(o_pro0[d]);
            end
            if (o_rv1[d] && t_rr1[d] && !t_rst[d]) begin
                hs_dut.push_back(d); hs_port.push_back(1); hs_pro.push_back(o_pro1[d]);
            end
            if (t_rst[d]) begin
                model_reset(d);
            end else if (m_inflight[d]) begin
                if ((m_age[d] >= 1) && (m_port[d] ? t_rr1[d] : t_rr0[d])) m_inflight[d] = 1'b0;
                else m_age[d]++;
            end else if (e_r0 || e_r1) begin
                pa = e_r1 ? int'(t_a1[d]) : int'(t_a0[d]);
                pb = e_r1 ? int'(t_b1[d]) : int'(t_b0[d]);
                m_inflight[d] = 1'b1;
                m_age[d]      = 0;
                m_port[d]     = e_r1;
                m_grant[d]    = e_r1;
                m_last[d]     = e_r1;
                m_exp[d]      = pa * pb;
                m_acc[d]++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic signed [15:0] rand_op();
        int sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return 16'sh8000;
        if (sel == 1) return 16'sh7fff;
        return $urandom();
    endfunction

    task automatic clear_hs();
        hs_dut.delete(); hs_port.delete(); hs_pro.delete();
    endtask

    initial begin
        int guard;
        bit done;
        t_rst = 2'b11; t_v0 = 2'b11; t_v1 = 2'b11; t_rr0 = 2'b11; t_rr1 = 2'b11;
        for (int d = 0; d < 2; d++) begin
            t_a0[d] = 16'sd300; t_b0[d] = -16'sd7; t_a1[d] = -16'sd1; t_b1[d] = -16'sd1;
            m_acc[d] = 0;
            model_reset(d);
        end
        t_v0[1] = 1'b0; t_v1[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        // Reset held with both requests pending: nothing may be accepted.
        tick();
        tick();
        t_rst = 2'b00;
        clear_hs();
        #1;
        check_value("release req0_ready", {31'd0, o_ready0[0]}, 32'd1);
        check_value("release req1_ready", {31'd0, o_ready1[0]}, 32'd0);
        guard = 0;
        while (hs_pro.size() < 2 && guard < 20) begin tick(); guard++; end
        t_v0 = 2'b00; t_v1 = 2'b00;
        check_value("tie count", hs_pro.size(), 32'd2);
        if (hs_pro.size() >= 2) begin
            check_value("tie first port", hs_port[0], 32'd0);
            check_value("tie first pro", hs_pro[0], -32'sd2100);
            check_value("tie second port", hs_port[1], 32'd1);
            check_value("tie second pro", hs_pro[1], 32'sd1);
        end
        repeat (3) tick();

        // Most-negative squared, with operands changed right after accept.
        t_v0[0] = 1'b1; t_a0[0] = 16'sh8000; t_b0[0] = 16'sh8000;
        tick();
        t_v0[0] = 1'b0; t_a0[0] = 16'sd5; t_b0[0] = 16'sd9;
        tick();
        check_value("min sq rsp0_valid", {31'd0, o_rv0[0]}, 32'd1);
        check_value("min sq rsp0_pro", o_pro0[0], 32'sd1073741824);
        check_value("min sq rsp1_valid", {31'd0, o_rv1[0]}, 32'd0);
        repeat (3) tick();

        // Backpressure on port 1 while port 0 keeps requesting.
        t_rr1[0] = 1'b0; t_v1[0] = 1'b1; t_a1[0] = 16'sd12345; t_b1[0] = -16'sd2;
        t_v0[0] = 1'b1; t_a0[0] = 16'sd7; t_b0[0] = 16'sd3;
        tick();
        t_v1[0] = 1'b0;
        repeat (6) tick();
        check_value("bp rsp1_valid", {31'd0, o_rv1[0]}, 32'd1);
        check_value("bp rsp1_pro", o_pro1[0], -32'sd24690);
        check_value("bp req0_ready", {31'd0, o_ready0[0]}, 32'd0);
        t_rr1[0] = 1'b1;
        repeat (4) tick();
        t_v0[0] = 1'b0;
        repeat (3) tick();

        // Reset while in CALC drops the transaction.
        t_v0[0] = 1'b1; t_a0[0] = 16'sd11; t_b0[0] = 16'sd13;
        tick();
        t_v0[0] = 1'b0; t_rst[0] = 1'b1;
        tick();
        t_rst[0] = 1'b0;
        check_value("midrst busy", {31'd0, o_busy[0]}, 32'd0);
        check_value("midrst rsp0_valid", {31'd0, o_rv0[0]}, 32'd0);
        repeat (3) tick();

        // Fixed priority: port 0 wins every transaction while it keeps requesting.
        clear_hs();
        t_v0[1] = 1'b1; t_v1[1] = 1'b1; t_rr0[1] = 1'b1; t_rr1[1] = 1'b1;
        guard = 0;
        while (hs_pro.size() < 4 && guard < 40) begin
            t_a0[1] = rand_op(); t_b0[1] = rand_op(); t_a1[1] = rand_op(); t_b1[1] = rand_op();
            tick(); guard++;
        end
        check_value("fp count", hs_pro.size(), 32'd4);
        for (int i = 0; i < hs_port.size(); i++) check_value("fp port0 wins", hs_port[i], 32'd0);
        t_v0[1] = 1'b0;
        clear_hs();
        guard = 0;
        while (hs_pro.size() < 1 && guard < 20) begin tick(); guard++; end
        check_value("fp port1 served", hs_pro.size(), 32'd1);
        if (hs_pro.size() >= 1) check_value("fp port1 idx", hs_port[0], 32'd1);
        t_v1[1] = 1'b0;
        repeat (3) tick();

        // Random traffic on both instances.
        m_acc[0] = 0; m_acc[1] = 0;
        guard = 0;
        done = 1'b0;
        while (!done && guard < 20000) begin
            for (int d = 0; d < 2; d++) begin
                t_v0[d]  = ($urandom_range(0, 3) != 0);
                t_v1[d]  = ($urandom_range(0, 3) != 0);
                t_rr0[d] = ($urandom_range(0, 3) != 0);
                t_rr1[d] = ($urandom_range(0, 3) != 0);
                t_rst[d] = ($urandom_range(0, 199) == 0);
                t_a0[d] = rand_op(); t_b0[d] = rand_op();
                t_a1[d] = rand_op(); t_b1[d] = rand_op();
            end
            tick();
            guard++;
            done = (m_acc[0] >= 1000) && (m_acc[1] >= 1000);
        end
        check_value("random budget", {31'd0, done}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
